// File: rtl/posit_defines.sv
// Shared width helpers and operand bundle type for the posit arithmetic datapath.
package posit_defines;

    typedef enum logic [0:0] {
        NORMAL,
        MULT
    } width_mode_e;

    localparam int unsigned DEF_POSIT_WIDTH = 8;
    localparam int unsigned DEF_POSIT_ES    = 0;

    // Scale spans [-(N-1)*2^ES, (N-1)*2^ES - 1]; a product of two needs one more bit.
    function automatic int unsigned get_scale_width(input int unsigned n, input int unsigned es,
                                                    input width_mode_e mode);
        int unsigned w;
        w = $clog2((n - 1) << es) + 1;
        if (mode == MULT) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int unsigned get_fraction_width(input int unsigned n, input int unsigned es,
                                                       input width_mode_e mode);
        int unsigned w;
        w = n - es - 3;
        if (mode == MULT) begin
            w = 2 * w + 1;
        end
        return w;
    endfunction

    function automatic int unsigned get_mult_scale_width(input int unsigned n,
                                                         input int unsigned es);
        return get_scale_width(n, es, MULT);
    endfunction

    function automatic int unsigned get_mult_fraction_width(input int unsigned n,
                                                            input int unsigned es);
        return get_fraction_width(n, es, MULT);
    endfunction

    localparam int unsigned DEF_SW = get_scale_width(DEF_POSIT_WIDTH, DEF_POSIT_ES, NORMAL);
    localparam int unsigned DEF_FW = get_fraction_width(DEF_POSIT_WIDTH, DEF_POSIT_ES, NORMAL);

    typedef struct packed {
        logic              sign;
        logic              inf;
        logic              zero;
        logic [DEF_SW-1:0] scale;
        logic [DEF_FW-1:0] fraction;
    } posit_unpacked_t;

endpackage

// File: rtl/posit_mult_normalize.sv
// Normalizes an exact mantissa product (1.0 <= P < 4.0) and applies NaR/zero override.
module posit_mult_normalize
    import posit_defines::*;
#(
    parameter int unsigned POSIT_WIDTH = 8,
    parameter int unsigned POSIT_ES    = 0,
    localparam int unsigned FW  = get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL),
    localparam int unsigned MSW = get_mult_scale_width(POSIT_WIDTH, POSIT_ES),
    localparam int unsigned MFW = get_mult_fraction_width(POSIT_WIDTH, POSIT_ES),
    localparam int unsigned PW  = 2 * FW + 2
) (
    input  logic [PW-1:0]  prod,
    input  logic [MSW-1:0] scale_sum,
    input  logic           prod_sign,
    input  logic           is_nar,
    input  logic           is_zero,
    output logic           sign,
    output logic           inf,
    output logic           zero,
    output logic [MSW-1:0] scale,
    output logic [MFW-1:0] fraction
);

    always_comb begin
        // MSB set means the product is in [2,4): drop that hidden bit and bump the scale.
        if (prod[PW-1]) begin
            fraction = prod[MFW-1:0];
            scale    = scale_sum + MSW'(1);
        end else begin
            fraction = {prod[MFW-2:0], 1'b0};
            scale    = scale_sum;
        end
        sign = prod_sign;
        inf  = 1'b0;
        zero = 1'b0;
        if (is_nar) begin
            sign     = 1'b1;
            inf      = 1'b1;
            scale    = '0;
            fraction = '0;
        end else if (is_zero) begin
            sign     = 1'b0;
            zero     = 1'b1;
            scale    = '0;
            fraction = '0;
        end
    end

endmodule

// File: rtl/posit_mult_core.sv
// Three-stage valid/ready multiplier producing an exact, unrounded decoded posit product.
module posit_mult_core
    import posit_defines::*;
#(
    parameter int unsigned POSIT_WIDTH = 8,
    parameter int unsigned POSIT_ES    = 0,
    localparam int unsigned SW  = get_scale_width(POSIT_WIDTH, POSIT_ES, NORMAL),
    localparam int unsigned FW  = get_fraction_width(POSIT_WIDTH, POSIT_ES, NORMAL),
    localparam int unsigned MSW = get_mult_scale_width(POSIT_WIDTH, POSIT_ES),
    localparam int unsigned MFW = get_mult_fraction_width(POSIT_WIDTH, POSIT_ES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rts_i,
    output logic           rtr_o,
    input  logic           a_sign,
    input  logic           a_inf,
    input  logic           a_zero,
    input  logic [SW-1:0]  a_scale,
    input  logic [FW-1:0]  a_fraction,
    input  logic           b_sign,
    input  logic           b_inf,
    input  logic           b_zero,
    input  logic [SW-1:0]  b_scale,
    input  logic [FW-1:0]  b_fraction,
    output logic           rts_o,
    input  logic           rtr_i,
    output logic           sign,
    output logic           inf,
    output logic           zero,
    output logic [MSW-1:0] scale,
    output logic [MFW-1:0] fraction
);

    localparam int unsigned PW = 2 * FW + 2;

    logic en;
    logic v1, v2, v3;

    logic          s1, n1, z1;
    logic [SW-1:0] a_scale1, b_scale1;
    logic [FW-1:0] a_frac1, b_frac1;

    logic           s2, n2, z2;
    logic [PW-1:0]  p2, p_d;
    logic [MSW-1:0] e2, e_d;

    logic           norm_sign, norm_inf, norm_zero;
    logic [MSW-1:0] norm_scale;
    logic [MFW-1:0] norm_fraction;

    // Single global enable: the whole pipe stalls only when the output slot is full.
    assign en    = ~v3 | rtr_i;
    assign rtr_o = en;
    assign rts_o = v3;

    always_comb begin
        p_d = {{(FW + 1){1'b0}}, 1'b1, a_frac1} * {{(FW + 1){1'b0}}, 1'b1, b_frac1};
        e_d = {a_scale1[SW-1], a_scale1} + {b_scale1[SW-1], b_scale1};
    end

    posit_mult_normalize #(
        .POSIT_WIDTH(POSIT_WIDTH),
        .POSIT_ES   (POSIT_ES)
    ) u_normalize (
        .prod     (p2),
        .scale_sum(e2),
        .prod_sign(s2),
        .is_nar   (n2),
        .is_zero  (z2),
        .sign     (norm_sign),
        .inf      (norm_inf),
        .zero     (norm_zero),
        .scale    (norm_scale),
        .fraction (norm_fraction)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1       <= 1'b0;
            n1       <= 1'b0;
            z1       <= 1'b0;
            a_scale1 <= '0;
            b_scale1 <= '0;
            a_frac1  <= '0;
            b_frac1  <= '0;
            s2       <= 1'b0;
            n2       <= 1'b0;
            z2       <= 1'b0;
            p2       <= '0;
            e2       <= '0;
            sign     <= 1'b0;
            inf      <= 1'b0;
            zero     <= 1'b0;
            scale    <= '0;
            fraction <= '0;
        end else if (en) begin
            v1       <= rts_i;
            s1       <= a_sign ^ b_sign;
            n1       <= a_inf | b_inf;
            z1       <= ~(a_inf | b_inf) & (a_zero | b_zero);
            a_scale1 <= a_scale;
            b_scale1 <= b_scale;
            a_frac1  <= a_fraction;
            b_frac1  <= b_fraction;

            v2 <= v1;
            s2 <= s1;
            n2 <= n1;
            z2 <= z1;
            p2 <= p_d;
            e2 <= e_d;

            v3       <= v2;
            sign     <= norm_sign;
            inf      <= norm_inf;
            zero     <= norm_zero;
            scale    <= norm_scale;
            fraction <= norm_fraction;
        end
    end

endmodule

// File: tb/tb_posit_mult_core.sv
// Bench for posit_mult_core (N=8, ES=0): directed cases, backpressure, reset and a random sweep.
module tb_posit_mult_core;

    typedef struct packed {
        logic       sign;
        logic       inf;
        logic       zero;
        logic [3:0] scale;
        logic [4:0] frac;
    } op_t;

    typedef struct packed {
        logic        sign;
        logic        inf;
        logic        zero;
        logic [4:0]  scale;
        logic [10:0] frac;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rts_i = 1'b0;
    logic        rtr_i = 1'b1;
    logic        rtr_o, rts_o, sign, inf, zero;
    logic [4:0]  scale;
    logic [10:0] fraction;
    op_t         a_op = '0;
    op_t         b_op = '0;

    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   out_cnt = 0;
    res_t exp_q[$];
    res_t prev_res = '0;
    logic prev_stall = 1'b0;

    op_t one, one5, two, neg_half, zro, nar, one25;
    res_t r_one, r_one5sq, r_four, r_neg1, r_zero, r_nar, r_one25sq;

    posit_mult_core #(
        .POSIT_WIDTH(8),
        .POSIT_ES   (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rts_i     (rts_i),
        .rtr_o     (rtr_o),
        .a_sign    (a_op.sign),
        .a_inf     (a_op.inf),
        .a_zero    (a_op.zero),
        .a_scale   (a_op.scale),
        .a_fraction(a_op.frac),
        .b_sign    (b_op.sign),
        .b_inf     (b_op.inf),
        .b_zero    (b_op.zero),
        .b_scale   (b_op.scale),
        .b_fraction(b_op.frac),
        .rts_o     (rts_o),
        .rtr_i     (rtr_i),
        .sign      (sign),
        .inf       (inf),
        .zero      (zero),
        .scale     (scale),
        .fraction  (fraction)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Operand value = (1 + frac/32) * 2^scale, so the exact product is prod/1024 * 2^(sa+sb).
    function automatic res_t model(input op_t a, input op_t b);
        res_t r;
        int   prod;
        int   sc;
        r = '0;
        if (a.inf || b.inf) begin
            r.sign = 1'b1;
            r.inf  = 1'b1;
            return r;
        end
        if (a.zero || b.zero) begin
            r.zero = 1'b1;
            return r;
        end
        prod = (32 + int'(a.frac)) * (32 + int'(b.frac));
        sc   = int'($signed(a.scale)) + int'($signed(b.scale));
        if (prod >= 2048) begin
            sc++;
            r.frac = 11'(prod - 2048);
        end else begin
            r.frac = 11'(2 * prod - 2048);
        end
        r.sign  = a.sign ^ b.sign;
        r.scale = 5'(sc);
        return r;
    endfunction

    function automatic op_t mk(input logic s, input int sc, input logic [4:0] f);
        op_t o;
        o       = '0;
        o.sign  = s;
        o.scale = 4'(sc);
        o.frac  = f;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  r;
        o.sign  = 1'($urandom_range(0, 1));
        o.scale = 4'($urandom_range(0, 12) - 6);
        o.frac  = 5'($urandom_range(0, 31));
        r       = int'($urandom_range(0, 15));
        o.inf   = (r == 0);
        o.zero  = (r == 1);
        if (o.inf || o.zero) begin
            o.sign  = o.inf;
            o.scale = '0;
            o.frac  = '0;
        end
        return o;
    endfunction

    function automatic res_t dut_res();
        return {sign, inf, zero, scale, fraction};
    endfunction

    // Scoreboard: every output transfer must match the model's next queued product.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("rtr_o_rule", rtr_o, !rts_o || rtr_i);
            if (prev_stall) begin
                chk("stall_hold", {rts_o, dut_res()}, {1'b1, prev_res});
            end
            if (rts_o && rtr_i) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", dut_res(), 32'hdead);
                end else begin
                    chk("result", dut_res(), exp_q.pop_front());
                    out_cnt++;
                end
            end
            if (rts_i && rtr_o) begin
                exp_q.push_back(model(a_op, b_op));
            end
            prev_stall = rts_o && !rtr_i;
            prev_res   = dut_res();
        end
    end

    task automatic send(input op_t a, input op_t b);
        int   t;
        logic ok;
        t     = 0;
        a_op  = a;
        b_op  = b;
        rts_i = 1'b1;
        do begin
            @(negedge clk);
            ok = rtr_o;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 50);
        if (!ok) chk("send_timeout", 0, 1);
        rts_i = 1'b0;
    endtask

    task automatic run_one(input string name, input op_t a, input op_t b, input res_t want);
        a_op  = a;
        b_op  = b;
        rts_i = 1'b1;
        @(posedge clk);
        #1;
        rts_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_rts"}, rts_o, 1);
        chk(name, dut_res(), want);
        @(negedge clk);
        chk({name, "_rts_low"}, rts_o, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_rts_o"}, rts_o, 0);
        chk({name, "_rtr_o"}, rtr_o, 1);
        chk({name, "_outs"}, dut_res(), 0);
    endtask

    initial begin
        int base;
        int sent;
        logic acc;

        fork
            begin
                #5_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        one      = mk(1'b0, 0, 5'b00000);
        one5     = mk(1'b0, 0, 5'b10000);
        two      = mk(1'b0, 1, 5'b00000);
        neg_half = mk(1'b1, -1, 5'b00000);
        one25    = mk(1'b0, 0, 5'b01000);
        zro      = '0;
        zro.zero = 1'b1;
        nar      = '0;
        nar.inf  = 1'b1;
        nar.sign = 1'b1;

        r_one     = {1'b0, 1'b0, 1'b0, 5'd0, 11'd0};
        r_one5sq  = {1'b0, 1'b0, 1'b0, 5'd1, 11'b00100000000};
        r_four    = {1'b0, 1'b0, 1'b0, 5'd2, 11'd0};
        r_neg1    = {1'b1, 1'b0, 1'b0, 5'd0, 11'd0};
        r_zero    = {1'b0, 1'b0, 1'b1, 5'd0, 11'd0};
        r_nar     = {1'b1, 1'b1, 1'b0, 5'd0, 11'd0};
        r_one25sq = {1'b0, 1'b0, 1'b0, 5'd0, 11'b10010000000};

        chk("model_1.5x1.5", model(one5, one5), r_one5sq);
        chk("model_1.25x1.25", model(one25, one25), r_one25sq);
        chk("model_nar_x_0", model(zro, nar), r_nar);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_one("mul_1.5x1.5", one5, one5, r_one5sq);
        run_one("mul_-0.5x2", neg_half, two, r_neg1);
        run_one("mul_nar_x_0", nar, zro, r_nar);
        run_one("mul_0_x_nar", zro, nar, r_nar);
        run_one("mul_0_x_1.5", zro, one5, r_zero);
        run_one("mul_1.25x1.25", one25, one25, r_one25sq);

        // Backpressure: output stalls while results keep arriving.
        base = out_cnt;
        fork
            begin
                send(one, one);
                send(one5, one5);
                send(two, two);
                send(zro, two);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                rtr_i = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_rts_o", rts_o, 1);
                    chk("bp_rtr_o", rtr_o, 0);
                    chk("bp_hold_1.0", dut_res(), r_one);
                end
                @(posedge clk);
                #1;
                rtr_i = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        chk("bp_count", out_cnt, base + 4);

        // Reset with two operations in flight.
        base = out_cnt;
        send(one5, one5);
        send(one, one);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        repeat (6) begin
            @(negedge clk);
            chk("midreset_quiet", rts_o, 0);
        end
        @(posedge clk);
        #1;
        chk("midreset_no_out", out_cnt, base);
        run_one("post_reset_2x2", two, two, r_four);

        // Random sweep with random flow control on both sides.
        sent = 0;
        acc  = 1'b0;
        while (sent < 10000) begin
            @(posedge clk);
            #1;
            rtr_i = ($urandom_range(0, 3) != 0);
            if (!rts_i || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    rts_i = 1'b1;
                    a_op  = rand_op();
                    b_op  = rand_op();
                end else begin
                    rts_i = 1'b0;
                end
            end
            @(negedge clk);
            acc = rts_i && rtr_o;
            if (acc) sent++;
        end
        @(posedge clk);
        #1;
        rts_i = 1'b0;
        rtr_i = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sweep_drained", exp_q.size(), 0);
        chk("sweep_idle", rts_o, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
